fd_multiciclo: RTL and testbench
================================

Name: fd_multiciclo

Overview:
- Multicycle RISC-V datapath.
- Holds PC, IR, 32-entry register file, immediate generator and ALU; exposes the fetched opcode and ALU flags.
- Executes the register-transfer actions requested by the control unit's per-cycle control signals: write enables, type code and mux selects.
- Sits between the control unit and the external instruction/data memories.

Parameters:
XLEN, 64, data/register/PC width in bits
PC_RESET, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
ir_we  in  1  load IR from i_mem_data (asserted by control unit in fetch)
pc_we  in  1  update PC (asserted by control unit in wb)
rf_we  in  1  register file write enable
alu_cmd  in  4  instruction type: 0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ
alu_src  in  1  ALU operand B: 1=immediate, 0=rs2
pc_src  in  1  next PC: 1=PC+imm, 0=PC+4
rf_src  in  1  register write data: 1=d_mem_rdata, 0=ALU result
opcode  out  7  IR[6:0] to control unit
alu_flags  out  4  [0]=zero, [1]=MSB of result, [2]=signed overflow, [3]=carry out
i_mem_addr  out  XLEN  equals PC
i_mem_data  in  32  instruction word
d_mem_addr  out  XLEN  ALU result
d_mem_wdata  out  XLEN  rs2 value
d_mem_rdata  in  XLEN  load data

Behaviour:
- Reset is sampled on a rising clk with rst_n=0:
  - PC <= PC_RESET.
  - IR <= 32'h00000013 (addi x0,x0,0), so opcode=7'b0010011.
  - All 32 registers <= 0.
  - rf_we, pc_we and ir_we are ignored in a reset cycle.
- IR: on a clk edge with ir_we=1, IR <= i_mem_data. Otherwise IR holds.
- Decode fields: rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7].
- Register file:
  - Reads are combinational.
  - x0 always reads 0. Writes to x0 are discarded.
  - Write on a clk edge when rf_we=1.
  - A write and a read of the same register in the same cycle: the read returns the old value until the edge.
- Immediate is sign-extended to XLEN and selected by alu_cmd:
  - I: IR[31:20].
  - S: {IR[31:25],IR[11:7]}.
  - SB: {IR[31],IR[7],IR[30:25],IR[11:8],0}.
  - U: {IR[31:12],12'b0}.
  - UJ: {IR[31],IR[19:12],IR[20],IR[30:21],0}.
  - R: 0.
- ALU operation by alu_cmd; operand B = alu_src ? imm : rs2:
  - R: rs1+B if IR[30]=0, rs1-B if IR[30]=1.
  - I, S: rs1+B.
  - SB: rs1-rs2, ignoring alu_src.
  - U: PC+imm (auipc).
  - UJ: PC+4 (link value).
  - Codes 6..15: result 0, flags 0.
- Arithmetic is modulo 2^XLEN.
  - Carry for subtraction = no-borrow.
  - Overflow uses the signed rule on the operands actually used.
- Flags are combinational from the current ALU result; they are not registered.
- Register write data: rf_src ? d_mem_rdata : ALU result.
- PC: on a clk edge with pc_we=1, PC <= pc_src ? PC+imm : PC+4. Wraps modulo 2^XLEN; no alignment check.
- Simultaneous events on one edge:
  - pc_we with rf_we: both use pre-edge PC, IR and registers, so jal links the old PC+4.
  - ir_we with pc_we: IR captures the instruction at the old PC.
- Reset mid-instruction: all state is restored as above on that edge; partially executed instructions have no further effect.
- Latency: all outputs are combinational from the current PC/IR/registers. State changes occur one clk edge after enable assertion.

Test Plan:
1. Reset, then ir_we=1 with i_mem_data=32'h00500093 (addi x1,x0,5), alu_cmd=1, alu_src=1, rf_we=1 -> opcode=7'b0010011; x1=5 after edge; i_mem_addr=0.
2. x1=5, x2=7, IR=sub x3,x1,x2 (32'h402081B3), alu_cmd=0, alu_src=0, rf_we=1 -> x3=64'hFFFF_FFFF_FFFF_FFFE; flags MSB=1, zero=0.
3. PC=8, IR=beq x1,x1,+16, alu_cmd=3 -> zero flag=1. pc_src=1, pc_we=1 -> PC=24. Repeat with pc_src=0 -> PC=12.
4. PC=16, IR=jal x5,+32, alu_cmd=5, rf_we=1, pc_we=1, pc_src=1 on the same edge -> x5=20, PC=48.
5. x1=64'h7FFF_FFFF_FFFF_FFFF, addi x2,x1,1 -> overflow=1, MSB=1; x2=64'h8000_0000_0000_0000. Separately, write to x0 with rf_we=1 -> x0 still reads 0.
6. sw, then lw path: d_mem_addr=rs1+imm, d_mem_wdata=rs2. With rf_src=1 and d_mem_rdata=64'hABCD, rd=64'hABCD. Then assert rst_n=0 mid-sequence -> PC=0, IR=NOP, all registers 0 next edge.

Source files
------------

// File: rtl/fd_multiciclo.sv
// Multicycle RISC-V datapath: PC, IR, register file, immediate generator and ALU.
// The control unit sequences it through per-cycle enables and mux selects.
module fd_multiciclo #(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ir_we,
  input  logic            pc_we,
  input  logic            rf_we,
  input  logic [3:0]      alu_cmd,
  input  logic            alu_src,
  input  logic            pc_src,
  input  logic            rf_src,
  output logic [6:0]      opcode,
  output logic [3:0]      alu_flags,
  output logic [XLEN-1:0] i_mem_addr,
  input  logic [31:0]     i_mem_data,
  output logic [XLEN-1:0] d_mem_addr,
  output logic [XLEN-1:0] d_mem_wdata,
  input  logic [XLEN-1:0] d_mem_rdata
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    CMD_R  = 4'd0,
    CMD_I  = 4'd1,
    CMD_S  = 4'd2,
    CMD_SB = 4'd3,
    CMD_U  = 4'd4,
    CMD_UJ = 4'd5
  } cmd_e;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];

  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, src_b;
  logic [XLEN-1:0] op_a, op_b, b_eff, alu_result, rf_wdata;
  logic [XLEN-1:0] pc_plus4, pc_plus_imm;
  logic [XLEN:0]   sum;
  logic            alu_sub, alu_valid, carry, overflow;

  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];
  assign rd_idx  = ir_q[11:7];
  assign rs1_val = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];

  always_comb begin
    imm = '0;
    case (alu_cmd)
      CMD_I:   imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      CMD_S:   imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      CMD_SB:  imm = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      CMD_U:   imm = {{(XLEN-32){ir_q[31]}}, ir_q[31:12], 12'b0};
      CMD_UJ:  imm = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign src_b       = alu_src ? imm : rs2_val;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign pc_plus_imm = pc_q + imm;

  // One shared adder; subtraction is a + ~b + 1, so carry out means no borrow.
  always_comb begin
    op_a      = rs1_val;
    op_b      = src_b;
    alu_sub   = 1'b0;
    alu_valid = 1'b1;
    case (alu_cmd)
      CMD_R:        alu_sub = ir_q[30];
      CMD_I, CMD_S: alu_sub = 1'b0;
      CMD_SB: begin
        op_b    = rs2_val;
        alu_sub = 1'b1;
      end
      CMD_U: begin
        op_a = pc_q;
        op_b = imm;
      end
      CMD_UJ: begin
        op_a = pc_q;
        op_b = XLEN'(4);
      end
      default: alu_valid = 1'b0;
    endcase
  end

  assign b_eff      = alu_sub ? ~op_b : op_b;
  assign sum        = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, alu_sub};
  assign alu_result = alu_valid ? sum[XLEN-1:0] : '0;
  assign carry      = sum[XLEN];
  assign overflow   = (op_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
  assign alu_flags  = alu_valid ? {carry, overflow, alu_result[XLEN-1], alu_result == '0} : 4'b0;

  assign rf_wdata    = rf_src ? d_mem_rdata : alu_result;
  assign opcode      = ir_q[6:0];
  assign i_mem_addr  = pc_q;
  assign d_mem_addr  = alu_result;
  assign d_mem_wdata = rs2_val;

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    rf_d = rf_q;
    if (pc_we) pc_d = pc_src ? pc_plus_imm : pc_plus4;
    if (ir_we) ir_d = i_mem_data;
    if (rf_we && (rd_idx != 5'd0)) rf_d[rd_idx] = rf_wdata;
  end

  // All next-state values above derive from pre-edge state, so a jal links the old PC+4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
      ir_q <= NOP;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      rf_q <= rf_d;
    end
  end

endmodule

// File: tb/tb_fd_multiciclo.sv
// Scoreboarded bench for fd_multiciclo: directed program sequences followed by
// randomized control/instruction traffic, checked against an ISA-level reference model.
module tb_fd_multiciclo;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n, ir_we, pc_we, rf_we, alu_src, pc_src, rf_src;
  logic [3:0]      alu_cmd;
  logic [6:0]      opcode;
  logic [3:0]      alu_flags;
  logic [XLEN-1:0] i_mem_addr, d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic [31:0]     i_mem_data;

  fd_multiciclo #(.XLEN(XLEN), .PC_RESET('0)) dut (
    .clk(clk), .rst_n(rst_n), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .alu_cmd(alu_cmd), .alu_src(alu_src), .pc_src(pc_src), .rf_src(rf_src),
    .opcode(opcode), .alu_flags(alu_flags), .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [3:0]  flags;
    logic [63:0] iaddr;
    logic [63:0] daddr;
    logic [63:0] wdata;
  } obs_t;

  obs_t exp_q[$];
  event sample_ev;
  int   errors = 0;
  int   checks = 0;

  // Architectural reference state
  logic [63:0] m_pc;
  logic [31:0] m_ir;
  logic [63:0] m_rf [32];

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] t;
    t = v << (64 - bits);
    return $unsigned($signed(t) >>> (64 - bits));
  endfunction

  function automatic logic [63:0] reg_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 64'd0 : m_rf[idx];
  endfunction

  function automatic logic [63:0] model_imm(input logic [3:0] cmd);
    case (cmd)
      4'd1:    return sext({52'd0, m_ir[31:20]}, 12);
      4'd2:    return sext({52'd0, m_ir[31:25], m_ir[11:7]}, 12);
      4'd3:    return sext({51'd0, m_ir[31], m_ir[7], m_ir[30:25], m_ir[11:8], 1'b0}, 13);
      4'd4:    return sext({32'd0, m_ir[31:12], 12'd0}, 32);
      4'd5:    return sext({43'd0, m_ir[31], m_ir[19:12], m_ir[20], m_ir[30:21], 1'b0}, 21);
      default: return 64'd0;
    endcase
  endfunction

  function automatic void model_alu(input logic [3:0] cmd, input logic asrc,
                                    output logic [63:0] res, output logic [3:0] fl);
    logic [63:0] a, b, imm;
    logic        is_sub, carry, ovf;
    logic signed [65:0] sa, sb, sw;
    imm    = model_imm(cmd);
    a      = reg_read(m_ir[19:15]);
    b      = asrc ? imm : reg_read(m_ir[24:20]);
    is_sub = 1'b0;
    case (cmd)
      4'd0: is_sub = m_ir[30];
      4'd1, 4'd2: is_sub = 1'b0;
      4'd3: begin b = reg_read(m_ir[24:20]); is_sub = 1'b1; end
      4'd4: begin a = m_pc; b = imm; end
      4'd5: begin a = m_pc; b = 64'd4; end
      default: begin res = 64'd0; fl = 4'd0; return; end
    endcase
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    if (is_sub) begin
      res   = a - b;
      carry = (a >= b);
      sw    = sa - sb;
    end else begin
      res   = a + b;
      carry = (({2'b0, a} + {2'b0, b}) > 66'h0_FFFF_FFFF_FFFF_FFFF);
      sw    = sa + sb;
    end
    ovf = (sw != $signed({{2{sw[63]}}, sw[63:0]}));
    fl  = {carry, ovf, res[63], res == 64'd0};
  endfunction

  function automatic obs_t model_obs();
    obs_t        o;
    logic [63:0] res;
    logic [3:0]  fl;
    model_alu(alu_cmd, alu_src, res, fl);
    o.opcode = m_ir[6:0];
    o.flags  = fl;
    o.iaddr  = m_pc;
    o.daddr  = res;
    o.wdata  = reg_read(m_ir[24:20]);
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every presented sample is matched against the oldest queued expectation
  initial begin : monitor
    obs_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        e = exp_q.pop_front();
        checkOutput("opcode",      64'(opcode),    64'(e.opcode));
        checkOutput("alu_flags",   64'(alu_flags), 64'(e.flags));
        checkOutput("i_mem_addr",  i_mem_addr,     e.iaddr);
        checkOutput("d_mem_addr",  d_mem_addr,     e.daddr);
        checkOutput("d_mem_wdata", d_mem_wdata,    e.wdata);
      end
    end
  end

  task automatic drive(input logic rst, input logic irwe, input logic [31:0] instr,
                       input logic [3:0] cmd, input logic asrc, input logic pcwe,
                       input logic psrc, input logic rfwe, input logic rsrc,
                       input logic [63:0] rdata);
    rst_n = rst; ir_we = irwe; i_mem_data = instr; alu_cmd = cmd; alu_src = asrc;
    pc_we = pcwe; pc_src = psrc; rf_we = rfwe; rf_src = rsrc; d_mem_rdata = rdata;
  endtask

  task automatic applyStimulus();
    #1;
    exp_q.push_back(model_obs());
    -> sample_ev;
    #1;
  endtask

  task automatic stepClock();
    logic [63:0] n_pc, res, wd;
    logic [31:0] n_ir;
    logic [3:0]  fl;
    logic [4:0]  rd;
    logic        wr;
    model_alu(alu_cmd, alu_src, res, fl);
    n_pc = pc_we ? (pc_src ? m_pc + model_imm(alu_cmd) : m_pc + 64'd4) : m_pc;
    n_ir = ir_we ? i_mem_data : m_ir;
    wd   = rf_src ? d_mem_rdata : res;
    rd   = m_ir[11:7];
    wr   = rf_we;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 64'd0;
      m_ir = 32'h0000_0013;
      for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    end else begin
      m_pc = n_pc;
      m_ir = n_ir;
      if (wr && rd != 5'd0) m_rf[rd] = wd;
    end
    @(negedge clk);
  endtask

  task automatic runCycle(input logic rst, input logic irwe, input logic [31:0] instr,
                          input logic [3:0] cmd, input logic asrc, input logic pcwe,
                          input logic psrc, input logic rfwe, input logic rsrc,
                          input logic [63:0] rdata);
    drive(rst, irwe, instr, cmd, asrc, pcwe, psrc, rfwe, rsrc, rdata);
    applyStimulus();
    stepClock();
  endtask

  task automatic fetch(input logic [31:0] instr);
    runCycle(1, 1, instr, 4'd1, 1, 0, 0, 0, 0, 64'd0);
  endtask

  task automatic readReg(input int r, input logic [63:0] expv, input string name);
    fetch(32'h0000_2023 | (32'(r) << 20));
    drive(1, 0, 32'd0, 4'd2, 1, 0, 0, 0, 0, 64'd0);
    applyStimulus();
    checkOutput(name, d_mem_wdata, expv);
    stepClock();
  endtask

  task automatic idleCheckPc(input logic [63:0] expv, input string name);
    drive(1, 0, 32'd0, 4'd1, 1, 0, 0, 0, 0, 64'd0);
    applyStimulus();
    checkOutput(name, i_mem_addr, expv);
    stepClock();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    drive(0, 0, 32'd0, 4'd0, 0, 0, 0, 0, 0, 64'd0);
    @(negedge clk);
    stepClock();

    // Reset state
    drive(1, 0, 32'd0, 4'd1, 1, 0, 0, 0, 0, 64'd0);
    applyStimulus();
    checkOutput("reset_opcode", 64'(opcode), 64'h13);
    checkOutput("reset_pc", i_mem_addr, 64'd0);
    stepClock();

    // addi x1,x0,5 ; addi x2,x0,7
    fetch(32'h0050_0093);
    drive(1, 0, 32'd0, 4'd1, 1, 0, 0, 1, 0, 64'd0);
    applyStimulus();
    checkOutput("addi_x1_result", d_mem_addr, 64'd5);
    stepClock();
    fetch(32'h0070_0113);
    runCycle(1, 0, 32'd0, 4'd1, 1, 0, 0, 1, 0, 64'd0);

    // sub x3,x1,x2
    fetch(32'h4020_81B3);
    drive(1, 0, 32'd0, 4'd0, 0, 0, 0, 1, 0, 64'd0);
    applyStimulus();
    checkOutput("sub_result", d_mem_addr, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("sub_msb", 64'(alu_flags[1]), 64'd1);
    checkOutput("sub_zero", 64'(alu_flags[0]), 64'd0);
    stepClock();
    readReg(3, 64'hFFFF_FFFF_FFFF_FFFE, "x3_after_sub");

    // beq x1,x1,+16 at PC=8, taken path
    runCycle(1, 0, 32'd0, 4'd1, 1, 1, 0, 0, 0, 64'd0);
    runCycle(1, 0, 32'd0, 4'd1, 1, 1, 0, 0, 0, 64'd0);
    idleCheckPc(64'd8, "pc_before_beq");
    fetch(32'h0010_8863);
    drive(1, 0, 32'd0, 4'd3, 0, 1, 1, 0, 0, 64'd0);
    applyStimulus();
    checkOutput("beq_zero", 64'(alu_flags[0]), 64'd1);
    stepClock();
    idleCheckPc(64'd24, "beq_taken_pc");

    // Same beq from PC=8, sequential path
    runCycle(0, 0, 32'd0, 4'd0, 0, 0, 0, 0, 0, 64'd0);
    runCycle(1, 0, 32'd0, 4'd1, 1, 1, 0, 0, 0, 64'd0);
    runCycle(1, 0, 32'd0, 4'd1, 1, 1, 0, 0, 0, 64'd0);
    fetch(32'h0010_8863);
    runCycle(1, 0, 32'd0, 4'd3, 0, 1, 0, 0, 0, 64'd0);
    idleCheckPc(64'd12, "beq_not_taken_pc");

    // jal x5,+32 at PC=16
    runCycle(1, 0, 32'd0, 4'd1, 1, 1, 0, 0, 0, 64'd0);
    fetch(32'h0200_02EF);
    drive(1, 0, 32'd0, 4'd5, 0, 1, 1, 1, 0, 64'd0);
    applyStimulus();
    checkOutput("jal_link", d_mem_addr, 64'd20);
    stepClock();
    idleCheckPc(64'd48, "jal_target_pc");
    readReg(5, 64'd20, "x5_link");

    // Signed overflow on addi, and x0 immutability
    fetch(32'h0000_0093);
    runCycle(1, 0, 32'd0, 4'd1, 1, 0, 0, 1, 1, 64'h7FFF_FFFF_FFFF_FFFF);
    fetch(32'h0010_8113);
    drive(1, 0, 32'd0, 4'd1, 1, 0, 0, 1, 0, 64'd0);
    applyStimulus();
    checkOutput("addi_ovf", 64'(alu_flags[2]), 64'd1);
    checkOutput("addi_ovf_msb", 64'(alu_flags[1]), 64'd1);
    checkOutput("addi_ovf_result", d_mem_addr, 64'h8000_0000_0000_0000);
    stepClock();
    fetch(32'h0010_8013);
    runCycle(1, 0, 32'd0, 4'd1, 1, 0, 0, 1, 0, 64'd0);
    readReg(0, 64'd0, "x0_after_write");
    readReg(2, 64'h8000_0000_0000_0000, "x2_after_ovf");

    // sw x2,8(x1) then ld x4,0(x1) returning 0xABCD
    fetch(32'h0020_A423);
    drive(1, 0, 32'd0, 4'd2, 1, 0, 0, 0, 0, 64'd0);
    applyStimulus();
    checkOutput("sw_addr", d_mem_addr, 64'h8000_0000_0000_0007);
    checkOutput("sw_wdata", d_mem_wdata, 64'h8000_0000_0000_0000);
    stepClock();
    fetch(32'h0000_B203);
    runCycle(1, 0, 32'd0, 4'd1, 1, 0, 0, 1, 1, 64'h0000_0000_0000_ABCD);
    readReg(4, 64'h0000_0000_0000_ABCD, "x4_load");

    // Reset asserted while every enable is active
    fetch(32'h0050_0093);
    runCycle(0, 1, 32'h0050_0093, 4'd1, 1, 1, 1, 1, 0, 64'd0);
    drive(1, 0, 32'd0, 4'd1, 1, 0, 0, 0, 0, 64'd0);
    applyStimulus();
    checkOutput("midreset_opcode", 64'(opcode), 64'h13);
    checkOutput("midreset_pc", i_mem_addr, 64'd0);
    stepClock();
    readReg(4, 64'd0, "x4_after_reset");
    readReg(1, 64'd0, "x1_after_reset");

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [3:0] cmd;
      cmd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      runCycle(($urandom_range(0, 59) != 0), 1'($urandom), $urandom, cmd, 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               {$urandom, $urandom});
    end

    #2;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
